// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer
// Instruction-fetch controller sitting between the PC/ROM pair and the
// execute stage. It reads one or two program bytes from the ROM addressed by
// the PC and assembles them into an instruction. The instruction is handed
// over on a valid/ready handshake. Jumps are resolved by loading the target
// address into the PC.
//
// Ports
//   clk, reset          clock (rising edge); asynchronous active-high reset
//   run                 level, permits fetching
//   pc [11:0]           current PC value fed back from the counter
//   program_byte [7:0]  ROM data at address pc (combinational)
//   flag_c, flag_z      carry / zero flags from the execute unit
//   instr_ready         execute unit accepts the presented instruction
//   pc_en               counter enable (combinational)
//   pc_load             counter load strobe (combinational)
//   pc_load_data [11:0] counter load value (combinational)
//   instr_valid         instruction presented (combinational)
//   opcode [3:0]        registered opcode
//   operand [3:0]       registered low nibble of byte 1
//   address [11:0]      registered {byte1[3:0], byte2}; 0 for one-byte ops
//   halted              high in the HALTED state
// ---------------------------------------------------------------------------
module fetch_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic [11:0] pc,
    input  logic [7:0]  program_byte,
    input  logic        flag_c,
    input  logic        flag_z,
    input  logic        instr_ready,
    output logic        pc_en,
    output logic        pc_load,
    output logic [11:0] pc_load_data,
    output logic        instr_valid,
    output logic [3:0]  opcode,
    output logic [3:0]  operand,
    output logic [11:0] address,
    output logic        halted
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH1 = 3'd1,
        S_FETCH2 = 3'd2,
        S_ISSUE  = 3'd3,
        S_HALTED = 3'd4
    } state_t;

    localparam logic [3:0] OP_HALT = 4'h7;
    localparam logic [3:0] OP_JMP  = 4'h8;
    localparam logic [3:0] OP_JC   = 4'h9;
    localparam logic [3:0] OP_JZ   = 4'hA;

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_opcode;
    logic [3:0]  r_operand;
    logic [11:0] r_address;
    logic        w_taken;

    // The PC is not a dependency here: the counter itself handles the
    // wrap-around, so the sequencer only observes it through program_byte.
    logic        w_unused_pc;
    assign w_unused_pc = ^pc;

    // Flags are looked at live, so only their value in the accept cycle
    // can matter.
    always_comb begin
        w_taken = 1'b0;
        case (r_opcode)
            OP_JMP:  w_taken = 1'b1;
            OP_JC:   w_taken = flag_c;
            OP_JZ:   w_taken = flag_z;
            default: w_taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        pc_en        = 1'b0;
        pc_load      = 1'b0;
        pc_load_data = 12'h000;
        instr_valid  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (run) w_next = S_FETCH1;
            end
            S_FETCH1: begin
                pc_en  = 1'b1;
                w_next = program_byte[7] ? S_FETCH2 : S_ISSUE;
            end
            S_FETCH2: begin
                pc_en  = 1'b1;
                w_next = S_ISSUE;
            end
            S_ISSUE: begin
                instr_valid = 1'b1;
                if (instr_ready) begin
                    if (w_taken) begin
                        pc_load      = 1'b1;
                        pc_load_data = r_address;
                    end
                    if (r_opcode == OP_HALT) w_next = S_HALTED;
                    else if (run)            w_next = S_FETCH1;
                    else                     w_next = S_IDLE;
                end
            end
            S_HALTED: begin
                if (!run) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Instruction fields only change while fetching, which keeps them
    // stable for the whole of ISSUE regardless of backpressure.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_opcode  <= 4'h0;
            r_operand <= 4'h0;
            r_address <= 12'h000;
        end else begin
            case (r_state)
                S_FETCH1: begin
                    r_opcode  <= program_byte[7:4];
                    r_operand <= program_byte[3:0];
                    if (!program_byte[7]) r_address <= 12'h000;
                end
                S_FETCH2: r_address <= {r_operand, program_byte};
                default: ;
            endcase
        end
    end

    assign opcode  = r_opcode;
    assign operand = r_operand;
    assign address = r_address;
    assign halted  = (r_state == S_HALTED);

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic [11:0] pc;
    logic [7:0]  program_byte;
    logic        flag_c;
    logic        flag_z;
    logic        instr_ready;
    logic        pc_en;
    logic        pc_load;
    logic [11:0] pc_load_data;
    logic        instr_valid;
    logic [3:0]  opcode;
    logic [3:0]  operand;
    logic [11:0] address;
    logic        halted;

    logic [7:0]  rom [4096];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    fetch_sequencer dut (
        .clk(clk), .reset(reset), .run(run), .pc(pc),
        .program_byte(program_byte), .flag_c(flag_c), .flag_z(flag_z),
        .instr_ready(instr_ready), .pc_en(pc_en), .pc_load(pc_load),
        .pc_load_data(pc_load_data), .instr_valid(instr_valid),
        .opcode(opcode), .operand(operand), .address(address),
        .halted(halted)
    );

    // Program counter and ROM that the sequencer is meant to drive.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)        pc <= 12'h000;
        else if (pc_load) pc <= pc_load_data;
        else if (pc_en)   pc <= pc + 12'h001;
    end
    assign program_byte = rom[pc];

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        chk("en_load_excl", {11'd0, pc_en & pc_load}, 12'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1; run = 1'b0; instr_ready = 1'b1;
        flag_c = 1'b0; flag_z = 1'b0;
        for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
        step(); step();
        reset = 1'b0;
    endtask

    // Conditional jump at 0: two stall cycles with flags at stall value,
    // then flipped, then accept with flags at accept value.
    task automatic jump_case(input string tag, input logic [7:0] b1, input logic [7:0] b2,
                             input logic fc_s, input logic fz_s,
                             input logic fc_a, input logic fz_a,
                             input logic exp_load, input logic [11:0] exp_pc);
        do_reset();
        rom[0] = b1; rom[1] = b2;
        run = 1'b1; instr_ready = 1'b0; flag_c = fc_s; flag_z = fz_s;
        step(); step(); step();
        chk({tag, "_valid"}, {11'd0, instr_valid}, 12'd1);
        chk({tag, "_stall1_load"}, {11'd0, pc_load}, 12'd0);
        step();
        flag_c = ~fc_s; flag_z = ~fz_s; #1;
        chk({tag, "_stall2_load"}, {11'd0, pc_load}, 12'd0);
        chk({tag, "_stall_pc"}, pc, 12'h002);
        flag_c = fc_a; flag_z = fz_a; instr_ready = 1'b1; run = 1'b0; #1;
        chk({tag, "_load"}, {11'd0, pc_load}, {11'd0, exp_load});
        chk({tag, "_load_data"}, pc_load_data, exp_load ? 12'h100 : 12'h000);
        step();
        chk({tag, "_pc"}, pc, exp_pc);
        chk({tag, "_valid_fall"}, {11'd0, instr_valid}, 12'd0);
    endtask

    initial begin
        // ---- reset state and sequential fetch ----
        do_reset();
        reset = 1'b1; #1;
        chk("rst_valid", {11'd0, instr_valid}, 12'd0);
        chk("rst_pc_en", {11'd0, pc_en}, 12'd0);
        chk("rst_pc_load", {11'd0, pc_load}, 12'd0);
        chk("rst_load_data", pc_load_data, 12'h000);
        chk("rst_fields", {opcode, operand, 4'h0}, 12'h000);
        chk("rst_halted", {11'd0, halted}, 12'd0);
        reset = 1'b0;
        rom[0] = 8'h12; rom[1] = 8'h34; rom[2] = 8'h56;
        run = 1'b1;
        step();
        chk("seq_f1_pc_en", {11'd0, pc_en}, 12'd1);
        chk("seq_f1_valid", {11'd0, instr_valid}, 12'd0);
        step();
        chk("seq_i0", {instr_valid, 3'd0, opcode, operand}, {1'b1, 3'd0, 8'h12});
        chk("seq_i0_pc", pc, 12'h001);
        chk("seq_i0_addr", address, 12'h000);
        step(); step();
        chk("seq_i1", {instr_valid, 3'd0, opcode, operand}, {1'b1, 3'd0, 8'h34});
        chk("seq_i1_pc", pc, 12'h002);
        step(); step();
        chk("seq_i2", {instr_valid, 3'd0, opcode, operand}, {1'b1, 3'd0, 8'h56});
        chk("seq_i2_pc", pc, 12'h003);
        run = 1'b0;
        step();
        chk("seq_idle_valid", {11'd0, instr_valid}, 12'd0);
        chk("seq_idle_pc_en", {11'd0, pc_en}, 12'd0);

        // ---- unconditional jump ----
        do_reset();
        rom[0] = 8'h82; rom[1] = 8'h5A; rom[12'h25A] = 8'h13;
        run = 1'b1;
        step();
        step();
        chk("jmp_f2_pc_en", {11'd0, pc_en}, 12'd1);
        chk("jmp_f2_op", {8'd0, opcode}, 12'h008);
        step();
        chk("jmp_addr", address, 12'h25A);
        chk("jmp_load", {10'd0, pc_load, pc_en}, 12'd2);
        chk("jmp_load_data", pc_load_data, 12'h25A);
        step();
        chk("jmp_target_pc", pc, 12'h25A);
        chk("jmp_f1_pc_en", {11'd0, pc_en}, 12'd1);
        step();
        chk("jmp_target_instr", {instr_valid, 3'd0, opcode, operand}, {1'b1, 3'd0, 8'h13});
        run = 1'b0;
        step();

        // ---- conditional jumps, flags sampled at accept only ----
        jump_case("jc_nt", 8'h91, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 12'h002);
        jump_case("jc_t",  8'h91, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 12'h100);
        jump_case("jz_nt", 8'hA1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 12'h002);
        jump_case("jz_t",  8'hA1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 12'h100);

        // ---- backpressure on a two-byte non-jump ----
        do_reset();
        rom[0] = 8'hC3; rom[1] = 8'h7E;
        run = 1'b1; instr_ready = 1'b0; flag_c = 1'b1; flag_z = 1'b1;
        step(); step(); step();
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", {11'd0, instr_valid}, 12'd1);
            chk("bp_fields", {opcode, operand, 4'h0}, 12'hC30);
            chk("bp_addr", address, 12'h37E);
            chk("bp_pc", pc, 12'h002);
            chk("bp_ctrl", {10'd0, pc_en, pc_load}, 12'd0);
            step();
        end
        instr_ready = 1'b1; run = 1'b0; #1;
        chk("bp_accept_noload", {10'd0, pc_en, pc_load}, 12'd0);
        step();
        chk("bp_after_valid", {11'd0, instr_valid}, 12'd0);
        chk("bp_after_pc", pc, 12'h002);

        // ---- HALT and resume ----
        do_reset();
        rom[0] = 8'h70; rom[1] = 8'h45;
        run = 1'b1;
        step(); step();
        chk("halt_issue", {instr_valid, 3'd0, opcode, operand}, {1'b1, 3'd0, 8'h70});
        chk("halt_issue_halted", {11'd0, halted}, 12'd0);
        step();
        chk("halt_halted", {11'd0, halted}, 12'd1);
        chk("halt_pc", pc, 12'h001);
        chk("halt_ctrl", {9'd0, instr_valid, pc_en, pc_load}, 12'd0);
        step();
        chk("halt_stays", {11'd0, halted}, 12'd1);
        run = 1'b0;
        step();
        chk("halt_idle", {11'd0, halted}, 12'd0);
        run = 1'b1;
        step();
        chk("resume_pc", pc, 12'h001);
        chk("resume_pc_en", {11'd0, pc_en}, 12'd1);
        step();
        chk("resume_instr", {instr_valid, 3'd0, opcode, operand}, {1'b1, 3'd0, 8'h45});
        chk("resume_pc_next", pc, 12'h002);
        run = 1'b0;
        step();

        // ---- asynchronous reset in FETCH2 ----
        do_reset();
        rom[0] = 8'hB1; rom[1] = 8'h22;
        run = 1'b1;
        step(); step();
        chk("ar_f2_op", {opcode, operand, 4'h0}, 12'hB10);
        chk("ar_f2_pc_en", {11'd0, pc_en}, 12'd1);
        #2 reset = 1'b1;
        #1;
        chk("ar_fields", {opcode, operand, 4'h0}, 12'h000);
        chk("ar_addr", address, 12'h000);
        chk("ar_ctrl", {8'd0, pc_en, pc_load, instr_valid, halted}, 12'd0);
        chk("ar_load_data", pc_load_data, 12'h000);
        reset = 1'b0;

        // ---- two-byte op at 12'hFFF takes byte 2 from 12'h000 ----
        do_reset();
        rom[0] = 8'h8F; rom[1] = 8'hFF; rom[12'hFFF] = 8'hB4;
        run = 1'b1;
        step(); step(); step();
        chk("wrap_jmp_data", pc_load_data, 12'hFFF);
        rom[0] = 8'h10;
        step();
        chk("wrap_f1_pc", pc, 12'hFFF);
        step();
        chk("wrap_f2_pc", pc, 12'h000);
        step();
        chk("wrap_addr", address, 12'h410);
        chk("wrap_op", {opcode, operand, 4'h0}, 12'hB40);
        chk("wrap_pc", pc, 12'h001);
        run = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch controller that drives the 12-bit program counter's `enabled`, `load` and `loadData` inputs. It reads program bytes from the combinational program ROM addressed by the PC and assembles one- or two-byte instructions. It hands each instruction to the execute unit over a valid/ready handshake and resolves jumps by loading the target address into the PC. It sits between the PC/ROM pair and the execute/decode stage.

## Interface
- No parameters. All widths are fixed: 12-bit PC, 8-bit program byte, 4-bit opcode.
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `run`  in  1  level; permits fetching.
- `pc`  in  12  current PC value, fed back from the counter.
- `program_byte`  in  8  ROM data at address `pc`; valid in the same cycle.
- `flag_c`, `flag_z`  in  1 each  carry and zero flags from the execute unit.
- `instr_ready`  in  1  execute unit accepts the issued instruction.
- `pc_en`  out  1  drives counter `enabled`.
- `pc_load`  out  1  drives counter `load`.
- `pc_load_data`  out  12  drives counter `loadData`.
- `instr_valid`  out  1  instruction presented to the execute unit.
- `opcode`  out  4  registered opcode.
- `operand`  out  4  registered low nibble of byte 1.
- `address`  out  12  registered `{byte1[3:0], byte2[7:0]}`; holds 12'h000 for one-byte instructions.
- `halted`  out  1  high in HALTED state.

## Operation
- **Encoding**
  - Byte 1 is `{opcode, operand}`.
  - `opcode[3]=1`: two-byte instruction. Byte 2 is `address[7:0]` and `operand` supplies `address[11:8]`.
  - `opcode[3]=0`: one-byte instruction.
  - Opcode 4'h8 is JMP, 4'h9 is JC (taken if `flag_c`), 4'hA is JZ (taken if `flag_z`).
  - Opcodes 4'hB–4'hF are two-byte and never jump.
  - Opcode 4'h7 is HALT. All other opcodes pass through to the execute unit.
- **States:** IDLE, FETCH1, FETCH2, ISSUE, HALTED. Reset enters IDLE.
- **IDLE**
  - All control outputs low.
  - `run=1` moves to FETCH1 on the next edge.
- **FETCH1**
  - Latch `opcode <= program_byte[7:4]` and `operand <= program_byte[3:0]`.
  - `pc_en=1`.
  - If `opcode[3]` is set, go to FETCH2. Otherwise set `address <= 0` and go to ISSUE.
- **FETCH2**
  - Latch `address <= {operand, program_byte}`.
  - `pc_en=1`. Go to ISSUE.
- **ISSUE**
  - `instr_valid=1`; opcode, operand and address stay stable until accepted.
  - Accept occurs on the cycle where `instr_ready=1`.
  - On accept with a taken jump: `pc_load=1` and `pc_load_data=address`. Flags are sampled in the accept cycle.
  - On accept with HALT: go to HALTED.
  - On any other accept: go to FETCH1 if `run=1`, else IDLE.
  - Without accept: stay in ISSUE with `pc_en=0` and `pc_load=0`.
- **HALTED**
  - `halted=1`; all other control outputs low.
  - `run=0` moves to IDLE. Re-asserting `run` then resumes at the current PC, i.e. the byte after HALT.
- **Output rules**
  - `pc_en`, `pc_load`, `pc_load_data` and `instr_valid` are combinational from state and inputs. All other outputs are registered.
  - `pc_en` and `pc_load` are never high in the same cycle.
  - `pc_load_data` equals `address` whenever `pc_load=1`, and is 12'h000 otherwise.
- **Run deasserted mid-instruction:** if `run` falls in FETCH1 or FETCH2, the instruction still completes through ISSUE. `run` is only checked in IDLE and at accept.
- **Wrap-around:**
  - PC wrap 12'hFFF to 12'h000 is the counter's behaviour; the sequencer does not interfere.
  - A two-byte instruction whose first byte is at 12'hFFF takes its second byte from 12'h000.
- **Reset, at any time:**
  - State becomes IDLE.
  - `opcode`, `operand` and `address` become 0.
  - `instr_valid`, `pc_en`, `pc_load` and `halted` become 0, and `pc_load_data` becomes 12'h000.

## Timing
- One-byte instruction: FETCH1 then ISSUE, 2 cycles per instruction with `instr_ready` tied high.
- Two-byte instruction: 3 cycles.
- A taken jump adds no penalty. The PC holds the target at the edge ending the accept cycle, and FETCH1 in the next cycle reads the ROM at the target.
- PC increments at the end of each FETCH cycle. In ISSUE, `pc` already points at the next instruction.
- `instr_valid` rises 1 cycle (one-byte) or 2 cycles (two-byte) after entering FETCH1. It falls the cycle after accept.

## Test plan
- **Reset, then sequential fetch.** Reset, then `run=1` with ROM[0..2] = 8'h12, 8'h34, 8'h56 and ready held high.
  - `instr_valid` pulses 3 times with `opcode`/`operand` = 1/2, 3/4, 5/6.
  - `pc` reads 1, 2, 3 at each accept.
- **Unconditional jump.** ROM[0]=8'h82, ROM[1]=8'h5A, ready high.
  - ISSUE shows `address`=12'h25A with `pc_load=1` and `pc_load_data`=12'h25A.
  - The next FETCH1 sees `pc`=12'h25A.
- **Conditional jumps.** JC to 12'h100 with `flag_c=0` gives no load and `pc`=2. Repeat with `flag_c=1`: load 12'h100.
  - Repeat both cases for JZ with `flag_z`.
  - Toggle the flag during the stall cycles to confirm it is sampled at the accept cycle only.
- **Backpressure.** Hold `instr_ready=0` for 5 cycles in ISSUE.
  - `instr_valid` and the instruction fields stay stable, and `pc` does not change.
  - `pc_en`/`pc_load` stay 0 until accept.
- **HALT and resume.** ROM[0]=8'h70. After accept, `halted=1` and `pc`=1.
  - Drop `run`: IDLE. Raise `run`: fetch resumes from address 1.
- **Reset mid-operation and wrap.**
  - Assert reset in FETCH2: all outputs return to reset values immediately, without waiting for a clock edge.
  - Separately, place a two-byte op at 12'hFFF with ROM[0]=8'h10: `address` takes its low byte from 12'h000.
